// File: rtl/inst_rr_scheduler.sv
// rtl/inst_rr_scheduler.sv - round-robin grant of one shared slot among NUM_REQ leaf instances
module inst_rr_scheduler #(
   parameter int NUM_REQ  = 5,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 terr_q, terr_d;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic                 timeout_hit;
   logic                 normal_rel;

   // Two passes: ptr..NUM_REQ-1 first, then wrap to 0..ptr-1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req[j] && (j >= int'(ptr_q))) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
   end

   assign timeout_hit = (hold_q == HOLD_W'(MAX_HOLD - 1));
   assign normal_rel  = done[idx_q] || !req[idx_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      terr_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            grant_d = '0;
            hold_d  = '0;
            if (win_found) begin
               state_d          = ST_GRANT;
               grant_d[win_idx] = 1'b1;
               idx_d            = win_idx;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            hold_d = hold_q + HOLD_W'(1);
            if (normal_rel || timeout_hit) begin
               state_d = ST_GAP;
               grant_d = '0;
               hold_d  = '0;
               ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
               // A forced release is only an error when the grantee still wanted the slot.
               terr_d  = timeout_hit && !normal_rel;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         terr_q  <= terr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_idx   = idx_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// tb/tb_inst_rr_scheduler.sv - directed scoreboard bench for inst_rr_scheduler
module tb_inst_rr_scheduler;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic [4:0] done;
   logic [4:0] grant;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic       timeout_err;

   typedef struct packed {
      logic [4:0] g;
      logic [2:0] i;
      logic       t;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   inst_rr_scheduler #(
      .NUM_REQ (5),
      .IDX_W   (3),
      .MAX_HOLD(16),
      .HOLD_W  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] oh(input int g);
      logic [4:0] v;
      v = 5'b00001;
      return v << g;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, then compare outputs after the next rising edge.
   task automatic cyc(input string tag, input logic rs, input logic [4:0] r, input logic [4:0] d,
                      input logic [4:0] eg, input logic [2:0] ei, input logic et);
      exp_t e;
      rst_n = rs;
      req   = r;
      done  = d;
      exp_q.push_back('{g: eg, i: ei, t: et});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".grant"}, {3'b0, grant}, {3'b0, e.g});
      check({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, |e.g});
      check({tag, ".idx"}, {5'b0, grant_idx}, {5'b0, e.i});
      check({tag, ".terr"}, {7'b0, timeout_err}, {7'b0, e.t});
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      @(posedge clk);
      #1;

      cyc("reset", 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);

      // single requester, done after third grant cycle, regrant after gap
      cyc("t1.grant", 1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0);
      cyc("t1.hold1", 1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0);
      cyc("t1.hold2", 1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0);
      cyc("t1.rel",   1'b1, 5'b00001, 5'b00001, 5'b00000, 3'd0, 1'b0);
      cyc("t1.regr",  1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0);
      cyc("t1.drop",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);
      cyc("t1.idle",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);

      // full rotation 0,1,2,3,4,0 from a fresh reset
      cyc("t2.reset", 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         int g;
         g = k % 5;
         cyc($sformatf("t2.g%0d.start", k), 1'b1, 5'b11111, 5'b00000, oh(g), 3'(g), 1'b0);
         cyc($sformatf("t2.g%0d.hold", k),  1'b1, 5'b11111, 5'b00000, oh(g), 3'(g), 1'b0);
         cyc($sformatf("t2.g%0d.rel", k),   1'b1, 5'b11111, oh(g),    5'b00000, 3'(g), 1'b0);
      end
      cyc("t2.idle", 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);

      // ptr=2 after grant to 1: winner 4, then wrap to 1
      cyc("t3.g1",    1'b1, 5'b00010, 5'b00000, 5'b00010, 3'd1, 1'b0);
      cyc("t3.rel1",  1'b1, 5'b10010, 5'b00010, 5'b00000, 3'd1, 1'b0);
      cyc("t3.g4",    1'b1, 5'b10010, 5'b00000, 5'b10000, 3'd4, 1'b0);
      cyc("t3.rel4",  1'b1, 5'b10010, 5'b10000, 5'b00000, 3'd4, 1'b0);
      cyc("t3.wrap1", 1'b1, 5'b10010, 5'b00000, 5'b00010, 3'd1, 1'b0);
      cyc("t3.drop",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b0);
      cyc("t3.idle",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b0);

      // hold timeout: 16 grant cycles, one-cycle timeout_err, regrant after gap
      cyc("t4.g3", 1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
      for (int k = 0; k < 15; k++)
         cyc($sformatf("t4.hold%0d", k), 1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
      cyc("t4.tmo",   1'b1, 5'b01000, 5'b00000, 5'b00000, 3'd3, 1'b1);
      cyc("t4.regr",  1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
      cyc("t4.drop",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b0);
      cyc("t4.idle",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b0);

      // foreign done/req activity is ignored; grantee req drop releases
      cyc("t5.g2",    1'b1, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b0);
      cyc("t5.noise1", 1'b1, 5'b00110, 5'b10001, 5'b00100, 3'd2, 1'b0);
      cyc("t5.noise2", 1'b1, 5'b00100, 5'b00001, 5'b00100, 3'd2, 1'b0);
      cyc("t5.noise3", 1'b1, 5'b00110, 5'b10000, 5'b00100, 3'd2, 1'b0);
      cyc("t5.reqdrop", 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0);
      cyc("t5.idle",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0);

      // reset mid-grant to 3; ptr returns to 0
      cyc("t6.g3",    1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
      cyc("t6.hold",  1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
      cyc("t6.rst",   1'b0, 5'b01001, 5'b00000, 5'b00000, 3'd0, 1'b0);
      cyc("t6.g0",    1'b1, 5'b01001, 5'b00000, 5'b00001, 3'd0, 1'b0);

      // timeout coinciding with done is a normal release
      for (int k = 0; k < 15; k++)
         cyc($sformatf("t7.hold%0d", k), 1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b0);
      cyc("t7.tmo_done", 1'b1, 5'b00001, 5'b00001, 5'b00000, 3'd0, 1'b0);
      cyc("t7.idle",     1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_rr_scheduler.md
Name: inst_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource slot among the NUM_REQ leaf sub-instances of a generated hierarchy level. The default is 5, matching the inst_0..inst_4 fan-out.
- Grants exactly one requester at a time and holds the grant until that requester releases it or a hold timeout fires.
- Rotates priority after every release so each requester makes forward progress.
- Sits in the parent level, between the leaf instances and the shared resource.

Parameters:
- NUM_REQ, 5: number of requesters; legal range 2..16.
- IDX_W, 3: width of grant_idx; must satisfy 2^IDX_W >= NUM_REQ.
- MAX_HOLD, 16: maximum grant duration in cycles; legal range 2..2^HOLD_W.
- HOLD_W, 8: width of the internal hold counter.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  NUM_REQ  per-requester request level; must stay high while access is wanted.
- done  input  NUM_REQ  per-requester release pulse; only the bit of the current grantee is honoured.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when nobody is granted.
- grant_valid  output  1  high exactly when grant is non-zero.
- grant_idx  output  IDX_W  binary index of the grantee; holds its last value while grant_valid is low.
- timeout_err  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout_err=0.
  - Internal state: hold_cnt=0, ptr=0 (requester 0 has highest priority).
  - Reset mid-grant drops the grant at that edge with no timeout_err; ptr returns to 0.
- Arbitration (IDLE and GAP states):
  - Winner = first asserted req bit scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - With no req asserted, stay in or go to IDLE; outputs low.
- IDLE:
  - If req is non-zero at edge t, grant/grant_valid/grant_idx are registered at edge t+1 (1-cycle latency). state->GRANT, hold_cnt=0.
- GRANT (grantee g):
  - hold_cnt increments every cycle.
  - Release condition, evaluated every cycle, any of:
    - done[g]=1;
    - req[g]=0;
    - hold_cnt==MAX_HOLD-1 (timeout).
  - On release at edge t: grant=0 and grant_valid=0 from t+1, ptr=(g+1) mod NUM_REQ, state->GAP.
  - Timeout alone (no done[g], req[g] still high) also pulses timeout_err high for cycle t+1 only.
  - Timeout coinciding with done[g] or req[g] low counts as a normal release: no timeout_err.
  - Consequence: the grant lasts at most MAX_HOLD cycles.
  - done bits of non-granted requesters and req changes of others are ignored during GRANT.
- GAP:
  - Exactly one turnaround cycle with all grants low, so a new grant always starts at release+2.
  - Arbitration uses the updated ptr. Winner present -> GRANT next edge; else -> IDLE.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant never switches directly from one requester to another without a zero cycle.
- ptr wrap: after grantee NUM_REQ-1 releases, ptr=0.

Test Plan:
1. Reset, then req=5'b00001 held and done[0] pulsed 3 cycles after grant -> grant=00001 at cycle 1 after req, grant low for 1 cycle after done, regrant to 0 two cycles after release, no timeout_err.
2. req=5'b11111 held, each grantee pulses done on its 2nd grant cycle -> grant_idx order 0,1,2,3,4,0; one zero cycle between grants.
3. req=5'b10010 with ptr=2 (after a grant to 1) -> winner is 4; after 4 releases, ptr wraps to 0 and the next winner is 1.
4. req[3] held, no done, MAX_HOLD=16 -> grant high for exactly 16 cycles; timeout_err 1-cycle pulse as grant drops; regrant to 3 two cycles after the release edge.
5. During a grant to 2: done[0] and done[4] pulsed, req[1] toggled -> grant to 2 unaffected. Then req[2] dropped -> release next edge, no timeout_err.
6. rst_n low for one edge mid-grant to 3 -> all outputs 0 at that edge. After release of reset with req=5'b01001, winner is 0 (ptr reset).
